// File: rtl/mult_rr_sched_if.sv
// Operand-request / product bus for mult_rr_sched: two requester channels plus the shared result.
// master = requesters/control side, slave = the multiplier.
interface mult_rr_sched_if #(
   parameter int N = 4
);
   logic           req0;
   logic [N-1:0]   a0;
   logic [N-1:0]   b0;
   logic           req1;
   logic [N-1:0]   a1;
   logic [N-1:0]   b1;
   logic           ack0;
   logic           ack1;
   logic           busy;
   logic           done;
   logic           done_id;
   logic [2*N-1:0] saida;

   modport master (
      output req0, a0, b0, req1, a1, b1,
      input  ack0, ack1, busy, done, done_id, saida
   );

   modport slave (
      input  req0, a0, b0, req1, a1, b1,
      output ack0, ack1, busy, done, done_id, saida
   );
endinterface

// File: rtl/mult_rr_sched.sv
// Shift-add N x N multiplier shared by two requesters under round-robin arbitration.
// Optional MULT_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier bits are all zero.
module mult_rr_sched #(
   parameter int N = 4
) (
   input  logic             clk,
   input  logic             rst,
   mult_rr_sched_if.slave   bus
);
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_reg, state_next;
   logic [2*N-1:0] mcand_reg, mcand_next;
   logic [N-1:0]   mplier_reg, mplier_next;
   logic [2*N-1:0] acc_reg, acc_next;
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic           ptr_reg, ptr_next;   // last granted requester
   logic           id_reg, id_next;
   logic           done_id_reg, done_id_next;
   logic [2*N-1:0] saida_reg, saida_next;
   logic           ack0_reg, ack0_next;
   logic           ack1_reg, ack1_next;
   logic           grant1;
   logic           last_iter;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         mcand_reg   <= '0;
         mplier_reg  <= '0;
         acc_reg     <= '0;
         cnt_reg     <= '0;
         ptr_reg     <= 1'b1;
         id_reg      <= 1'b0;
         done_id_reg <= 1'b0;
         saida_reg   <= '0;
         ack0_reg    <= 1'b0;
         ack1_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         mcand_reg   <= mcand_next;
         mplier_reg  <= mplier_next;
         acc_reg     <= acc_next;
         cnt_reg     <= cnt_next;
         ptr_reg     <= ptr_next;
         id_reg      <= id_next;
         done_id_reg <= done_id_next;
         saida_reg   <= saida_next;
         ack0_reg    <= ack0_next;
         ack1_reg    <= ack1_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      mcand_next   = mcand_reg;
      mplier_next  = mplier_reg;
      acc_next     = acc_reg;
      cnt_next     = cnt_reg;
      ptr_next     = ptr_reg;
      id_next      = id_reg;
      done_id_next = done_id_reg;
      saida_next   = saida_reg;
      ack0_next    = 1'b0;
      ack1_next    = 1'b0;
      grant1       = 1'b0;
      last_iter    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               // requester 1 wins when alone, or when both ask and 0 was served last
               grant1      = bus.req1 && (!bus.req0 || !ptr_reg);
               mcand_next  = grant1 ? {{N{1'b0}}, bus.a1} : {{N{1'b0}}, bus.a0};
               mplier_next = grant1 ? bus.b1 : bus.b0;
               acc_next    = '0;
               cnt_next    = CW'(N);
               ptr_next    = grant1;
               id_next     = grant1;
               ack0_next   = !grant1;
               ack1_next   = grant1;
               state_next  = RUN;
            end
         end
         RUN: begin
            acc_next    = mplier_reg[0] ? acc_reg + mcand_reg : acc_reg;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            cnt_next    = cnt_reg - CW'(1);
`ifdef MULT_EARLY_EXIT_EN
            last_iter   = (cnt_reg == CW'(1)) || (mplier_next == '0);
`else
            last_iter   = (cnt_reg == CW'(1));
`endif
            if (last_iter) begin
               // product and owner are presented together for the whole DONE cycle
               saida_next   = acc_next;
               done_id_next = id_reg;
               state_next   = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.ack0    = ack0_reg;
   assign bus.ack1    = ack1_reg;
   assign bus.busy    = (state_reg != IDLE);
   assign bus.done    = (state_reg == DONE);
   assign bus.done_id = done_id_reg;
   assign bus.saida   = saida_reg;
endmodule
